// File: rtl/cla_div32_seq_pkg.sv
// Shared constants for the sequential CLA-based divider: FSM encoding, counter width, divide-by-zero quotient.
// Pure declarations; no latency or flow control of its own.
package cla_div32_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          CNT_W       = 5;
    localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/cla_div32_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
// Purely combinational; no flow control.
module cla_div32_seq_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] p;
    logic [31:0] g;
    logic [31:0] c;
    logic        carry;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c     = '0;
        carry = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = carry;
            c[4*k+1] = g[4*k] | (p[4*k] & carry);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            carry    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & carry);
        end
    end

    assign s  = p ^ c;
    assign co = carry;

endmodule

// File: rtl/cla_div32_seq.sv
// Iterative unsigned restoring divider, one trial subtraction per enabled cycle (result 33 cycles after accept).
// Single operation in flight; result held in DONE until out_ready, en=0 freezes everything.
module cla_div32_seq
    import cla_div32_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] q_r;
    // Partial remainder is always < divisor, so its extra top bit is provably zero and not stored.
    logic [WIDTH-1:0] r_r;

    logic [WIDTH:0]   rs;
    logic [WIDTH-1:0] low;
    logic             co;
    logic             nonneg;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign rs     = {r_r, q_r[WIDTH-1]};
    assign nonneg = rs[WIDTH] | co;
    assign r_next = nonneg ? low : rs[WIDTH-1:0];
    assign q_next = {q_r[WIDTH-2:0], nonneg};

    cla_div32_seq_cla32 u_sub (
        .a  (rs[WIDTH-1:0]),
        .b  (~d_r),
        .ci (1'b1),
        .s  (low),
        .co (co)
    );

    assign in_ready = en && (state == IDLE);
    assign busy     = (state == CALC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            d_r         <= '0;
            q_r         <= '0;
            r_r         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_r <= divisor;
                        q_r <= dividend;
                        r_r <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= DZ_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_r <= q_next;
                    r_r <= r_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
